// File: rtl/l2_ecc_scrub_ctrl.sv
// Background ECC scrubber for the L2: walks every word at a programmable rate,
// writes back corrected data and records uncorrectable errors.
module l2_ecc_scrub_ctrl #(
  parameter int unsigned           AddrWidth = 32,
  parameter int unsigned           DataWidth = 64,
  parameter logic [AddrWidth-1:0]  L2Base    = 32'h7800_0000,
  parameter logic [AddrWidth-1:0]  L2Size    = 32'h0040_0000,
  parameter int unsigned           CntWidth  = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 enable_i,
  input  logic [CntWidth-1:0]  interval_i,
  input  logic                 clear_cnt_i,
  input  logic                 port_busy_i,
  output logic                 scrub_req_o,
  output logic                 scrub_we_o,
  output logic [AddrWidth-1:0] scrub_addr_o,
  output logic [DataWidth-1:0] scrub_wdata_o,
  input  logic                 scrub_gnt_i,
  input  logic                 scrub_rvalid_i,
  input  logic [DataWidth-1:0] scrub_rdata_i,
  input  logic                 ecc_single_err_i,
  input  logic                 ecc_multi_err_i,
  output logic                 pass_done_o,
  output logic [CntWidth-1:0]  corrected_cnt_o,
  output logic [CntWidth-1:0]  uncorrectable_cnt_o,
  output logic [AddrWidth-1:0] fail_addr_o,
  output logic                 uncorrectable_irq_o
);

  localparam logic [AddrWidth-1:0] Stride   = AddrWidth'(DataWidth / 8);
  localparam logic [AddrWidth-1:0] LastAddr = L2Base + L2Size - Stride;

  typedef enum logic [2:0] {IDLE, WAIT, RD_REQ, RD_RSP, WR_REQ} state_e;

  state_e               state_q, state_d;
  logic [AddrWidth-1:0] ptr_q, ptr_d;
  logic [CntWidth-1:0]  cnt_q, cnt_d;
  logic                 hold_q, hold_d;
  logic [DataWidth-1:0] wdata_q, wdata_d;
  logic [CntWidth-1:0]  corr_q, corr_d;
  logic [CntWidth-1:0]  unc_q, unc_d;
  logic [AddrWidth-1:0] fail_q, fail_d;
  logic                 irq_q, irq_d;
  logic                 advance;
  logic                 req;

  function automatic logic [CntWidth-1:0] sat_inc(input logic [CntWidth-1:0] v);
    return (&v) ? v : v + CntWidth'(1);
  endfunction

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    hold_d      = hold_q;
    wdata_d     = wdata_q;
    corr_d      = corr_q;
    unc_d       = unc_q;
    fail_d      = fail_q;
    irq_d       = irq_q;
    advance     = 1'b0;
    req         = 1'b0;
    pass_done_o = 1'b0;

    case (state_q)
      IDLE: begin
        if (enable_i) begin
          cnt_d   = interval_i;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == '0) state_d = RD_REQ;
        else             cnt_d   = cnt_q - CntWidth'(1);
      end
      RD_REQ, WR_REQ: begin
        // Once raised, the request stays up until granted even if busy rises.
        req = hold_q | ~port_busy_i;
        if (req && scrub_gnt_i) begin
          hold_d = 1'b0;
          if (state_q == RD_REQ) state_d = RD_RSP;
          else                   advance = 1'b1;
        end else if (req) begin
          hold_d = 1'b1;
        end
      end
      RD_RSP: begin
        if (scrub_rvalid_i) begin
          if (ecc_multi_err_i) begin
            unc_d = sat_inc(unc_q);
            if (!irq_q) begin
              fail_d = ptr_q;
              irq_d  = 1'b1;
            end
            advance = 1'b1;
          end else if (ecc_single_err_i) begin
            wdata_d = scrub_rdata_i;
            corr_d  = sat_inc(corr_q);
            state_d = WR_REQ;
          end else begin
            advance = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (advance) begin
      pass_done_o = (ptr_q == LastAddr);
      ptr_d       = (ptr_q == LastAddr) ? L2Base : ptr_q + Stride;
      cnt_d       = interval_i;
      state_d     = enable_i ? WAIT : IDLE;
    end

    if (clear_cnt_i) begin
      corr_d = '0;
      unc_d  = '0;
      fail_d = '0;
      irq_d  = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      ptr_q   <= L2Base;
      cnt_q   <= '0;
      hold_q  <= 1'b0;
      wdata_q <= '0;
      corr_q  <= '0;
      unc_q   <= '0;
      fail_q  <= '0;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      wdata_q <= wdata_d;
      corr_q  <= corr_d;
      unc_q   <= unc_d;
      fail_q  <= fail_d;
      irq_q   <= irq_d;
    end
  end

  assign scrub_req_o         = req;
  assign scrub_we_o          = (state_q == WR_REQ);
  assign scrub_addr_o        = ptr_q;
  assign scrub_wdata_o       = wdata_q;
  assign corrected_cnt_o     = corr_q;
  assign uncorrectable_cnt_o = unc_q;
  assign fail_addr_o         = fail_q;
  assign uncorrectable_irq_o = irq_q;

endmodule

// File: doc/l2_ecc_scrub_ctrl.md
Name: l2_ecc_scrub_ctrl

Overview:
Background ECC scrubber controller for the dual-port L2 (two 2 MiB ports, contiguous from 0x7800_0000). It walks every 64-bit L2 word at a programmable rate and issues a read. On a correctable error it writes the corrected data back; on an uncorrectable error it records the error and interrupts. It owns one request port into the L2 ECC wrapper and yields to functional traffic, which has strict priority on that port.

Parameters:
AddrWidth, 32, byte address width
DataWidth, 64, L2 word width; word stride = DataWidth/8 bytes
L2Base, 32'h7800_0000, first scrubbed byte address
L2Size, 32'h0040_0000, bytes scrubbed per pass (both ports)
CntWidth, 16, width of the interval and error counters

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous reset, active-high
enable_i  in  1  scrubbing enabled
interval_i  in  CntWidth  idle cycles between word scrubs
clear_cnt_i  in  1  clears counters and sticky fail state
port_busy_i  in  1  functional master is using the L2 port this cycle
scrub_req_o  out  1  memory request valid
scrub_we_o  out  1  1 = write-back, 0 = read
scrub_addr_o  out  AddrWidth  word-aligned byte address
scrub_wdata_o  out  DataWidth  corrected data to write back
scrub_gnt_i  in  1  request accepted
scrub_rvalid_i  in  1  read response valid
scrub_rdata_i  in  DataWidth  corrected read data
ecc_single_err_i  in  1  correctable error, qualified by scrub_rvalid_i
ecc_multi_err_i  in  1  uncorrectable error, qualified by scrub_rvalid_i
pass_done_o  out  1  one-cycle pulse when the last word of a pass completes
corrected_cnt_o  out  CntWidth  correctable errors seen, saturating
uncorrectable_cnt_o  out  CntWidth  uncorrectable errors seen, saturating
fail_addr_o  out  AddrWidth  address of the first uncorrectable error since clear
uncorrectable_irq_o  out  1  level interrupt, sticky until clear_cnt_i

Behaviour:
- Reset values:
  - all outputs 0, except scrub_addr_o = L2Base.
  - FSM = IDLE; address pointer = L2Base; interval counter = 0.
- FSM states: IDLE, WAIT, RD_REQ, RD_RSP, WR_REQ.
- IDLE: when enable_i = 1, load interval counter with interval_i and go to WAIT.
- WAIT:
  - decrement the counter each cycle.
  - at 0, go to RD_REQ.
  - interval_i = 0 means 0 wait cycles, i.e. WAIT lasts exactly 1 cycle.
- RD_REQ:
  - scrub_req_o = ~port_busy_i, scrub_we_o = 0.
  - on req & gnt, go to RD_RSP.
  - while port_busy_i = 1, no request is issued; address and state are held.
- RD_RSP:
  - wait for scrub_rvalid_i; no timeout.
  - ecc_multi_err_i set: saturating-increment uncorrectable_cnt_o. If the irq is not yet set, capture the address into fail_addr_o and set the irq. Then advance.
  - else ecc_single_err_i set: register scrub_rdata_i into scrub_wdata_o, saturating-increment corrected_cnt_o, go to WR_REQ.
  - else: advance.
  - both error flags set together: treated as multi only.
- WR_REQ:
  - same request rules as RD_REQ, but scrub_we_o = 1 and the address is unchanged.
  - on gnt, advance. No write response is awaited.
- Advance:
  - pointer += DataWidth/8.
  - if pointer was L2Base + L2Size - DataWidth/8: wrap to L2Base and pulse pass_done_o in the same cycle.
  - then, if enable_i = 1, go to WAIT (reload the counter); otherwise go to IDLE.
- enable_i deasserted mid-operation: the current word completes through its read and any write-back, then the FSM goes to IDLE. The pointer is kept, so re-enabling resumes at the next word.
- A request, once asserted with port_busy_i = 0, holds address, we and wdata stable until gnt, even if port_busy_i rises afterwards.
- clear_cnt_i zeroes both counters, fail_addr_o and the irq.
  - It has priority over a same-cycle increment: that increment is lost.
  - It does not affect the FSM or the pointer.
- Counters saturate at all-ones.
- Reset mid-transaction: abort immediately and return to reset values. An outstanding response arriving after reset, while in IDLE, is ignored.
- Latency: with no contention, gnt in the request cycle, rvalid one cycle later and no error, one word takes interval_i + 3 cycles (WAIT + RD_REQ + RD_RSP).

Test Plan:
- Clean pass: L2Size = 0x20 (4 words), interval_i = 2, zero-latency memory, no errors → reads at 0x7800_0000, _0008, _0010, _0018. Each read is 5 cycles after the previous one. pass_done_o pulses with the 4th response; the next read is at 0x7800_0000.
- Correctable error: single_err on the word at 0x7800_0008 with rdata = 0xDEAD_BEEF_0123_4567 → the next request is a write to 0x7800_0008 with that wdata; corrected_cnt_o = 1.
- Uncorrectable errors: multi_err at 0x7800_0010, then at 0x7800_0018 → irq = 1, fail_addr_o stays 0x7800_0010, uncorrectable_cnt_o = 2. clear_cnt_i → all zero. A same-cycle error with clear is not counted.
- Contention: port_busy_i high for 10 cycles during RD_REQ → no scrub_req_o in those cycles; the request issues the cycle busy falls, with the address unchanged. Busy rising after req, gnt delayed 3 cycles → addr/we stay stable throughout.
- Disable mid-word: drop enable_i during RD_RSP on a single-error word → the write-back still occurs, then IDLE. Re-enable → the next read is at the next word address.
- Saturation and reset: force 0xFFFF correctable errors plus one more → corrected_cnt_o stays 0xFFFF. Assert rst_i during WR_REQ → req = 0, pointer = L2Base on the next cycle.
